// File: rtl/axi_apb_pkg.sv
// axi_apb_pkg: shared types and default widths for the AXI4-Lite-to-APB bridge
package axi_apb_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_state_t;
endpackage

// File: rtl/apb_master_fsm_if.sv
// apb_master_fsm_if: request/response channel and APB bus seen by apb_master_fsm
interface apb_master_fsm_if #(
  parameter int addrWidth = axi_apb_pkg::ADDR_W,
  parameter int dataWidth = axi_apb_pkg::DATA_W
);
  logic                   req_valid;
  logic                   req_ready;
  logic                   req_write;
  logic [addrWidth-1:0]   req_addr;
  logic [dataWidth-1:0]   req_wdata;
  logic [dataWidth/8-1:0] req_strb;
  logic [2:0]             req_prot;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic                   rsp_write;
  logic [dataWidth-1:0]   rsp_rdata;
  logic [1:0]             rsp_resp;
  logic [addrWidth-1:0]   paddr;
  logic                   psel;
  logic                   penable;
  logic                   pwrite;
  logic [dataWidth-1:0]   pwdata;
  logic [dataWidth/8-1:0] pstrb;
  logic [2:0]             pprot;
  logic [dataWidth-1:0]   prdata;
  logic                   pready;
  logic                   pslverr;
  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_strb, req_prot,
    input  rsp_ready, prdata, pready, pslverr,
    output req_ready, rsp_valid, rsp_write, rsp_rdata, rsp_resp,
    output paddr, psel, penable, pwrite, pwdata, pstrb, pprot
  );
  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_strb, req_prot,
    output rsp_ready, prdata, pready, pslverr,
    input  req_ready, rsp_valid, rsp_write, rsp_rdata, rsp_resp,
    input  paddr, psel, penable, pwrite, pwdata, pstrb, pprot
  );
endinterface

// File: rtl/apb_wait_timer.sv
// apb_wait_timer: counts ACCESS wait cycles and flags the cycle that reaches the limit
module apb_wait_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic expire_o
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q;
  // wait counter, cleared while SETUP so it starts from zero in ACCESS
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (inc_i) cnt_q <= cnt_q + 1'b1;
  end
  assign expire_o = inc_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/apb_master_fsm.sv
// apb_master_fsm: runs one captured request as an APB SETUP/ACCESS transfer; APB_TIMEOUT_EN adds an ACCESS wait limit
module apb_master_fsm
  import axi_apb_pkg::*;
#(
  parameter int addrWidth      = ADDR_W,
  parameter int dataWidth      = DATA_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic              clk,
  input logic              rst,
  apb_master_fsm_if.master bus
);
  apb_state_t             state_q;
  logic                   req_ready_q;
  logic                   psel_q;
  logic                   penable_q;
  logic                   rsp_valid_q;
  logic                   rsp_write_q;
  logic [dataWidth-1:0]   rsp_rdata_q;
  resp_t                  rsp_resp_q;
  logic [addrWidth-1:0]   paddr_q;
  logic                   pwrite_q;
  logic [dataWidth-1:0]   pwdata_q;
  logic [dataWidth/8-1:0] pstrb_q;
  logic [2:0]             pprot_q;
  logic                   tmo;
  generate
    if (TIMEOUT_CYCLES < 1 || !(dataWidth inside {8, 16, 32})) begin : g_bad_cfg
      $error("apb_master_fsm: dataWidth must be 8/16/32 and TIMEOUT_CYCLES >= 1");
    end
  endgenerate
`ifdef APB_TIMEOUT_EN
  apb_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (state_q == SETUP),
    .inc_i   (state_q == ACCESS && !bus.pready),
    .expire_o(tmo)
  );
`else
  assign tmo = 1'b0;
`endif
  // transfer sequencer; every bus output is a register updated with the state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= OKAY;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      pprot_q     <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.req_valid) begin
          state_q     <= SETUP;
          req_ready_q <= 1'b0;
          psel_q      <= 1'b1;
          paddr_q     <= bus.req_addr;
          pwrite_q    <= bus.req_write;
          pwdata_q    <= bus.req_wdata;
          pstrb_q     <= bus.req_write ? bus.req_strb : '0;
          pprot_q     <= bus.req_prot;
        end
        SETUP: begin
          state_q   <= ACCESS;
          penable_q <= 1'b1;
        end
        ACCESS: if (bus.pready || tmo) begin
          state_q     <= RESP;
          psel_q      <= 1'b0;
          penable_q   <= 1'b0;
          rsp_valid_q <= 1'b1;
          rsp_write_q <= pwrite_q;
          rsp_rdata_q <= (pwrite_q || !bus.pready) ? '0 : bus.prdata;
          rsp_resp_q  <= (!bus.pready || bus.pslverr) ? SLVERR : OKAY;
        end
        RESP: if (bus.rsp_ready) begin
          state_q     <= IDLE;
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_write = rsp_write_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_resp  = rsp_resp_q;
  assign bus.paddr     = paddr_q;
  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.pstrb     = pstrb_q;
  assign bus.pprot     = pprot_q;
endmodule

// File: tb/tb_apb_master_fsm.sv
// tb_apb_master_fsm: vector table, reset abort and random transfers checked against a transfer-level model
module tb_apb_master_fsm;
  localparam int TO = 4;
  typedef struct {
    logic        w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    int          waits;
    logic [31:0] prdata;
    logic        err;
    int          bp;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
    logic [3:0]  exp_pstrb;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int passed = 0;
  int total = 0;
  vec_t tbl[7];
  vec_t v;
  apb_master_fsm_if #(.addrWidth(32), .dataWidth(32)) bus ();
  apb_master_fsm #(.addrWidth(32), .dataWidth(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, required %0h", nm, act, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic timed_out(input int waits);
`ifdef APB_TIMEOUT_EN
    return waits >= TO;
`else
    return 1'b0;
`endif
  endfunction
  function automatic vec_t ref_model(input vec_t r);
    vec_t o = r;
    logic t = timed_out(r.waits);
    o.exp_resp  = (t || r.err) ? 2'b10 : 2'b00;
    o.exp_rdata = (r.w || t) ? 32'h0 : r.prdata;
    o.exp_pstrb = r.w ? r.strb : 4'h0;
    return o;
  endfunction
  task automatic apb_chk(input string ph, input vec_t r);
    chk({ph, "_paddr"}, bus.paddr, r.addr);
    chk({ph, "_pwrite"}, 32'(bus.pwrite), 32'(r.w));
    chk({ph, "_pwdata"}, bus.pwdata, r.wdata);
    chk({ph, "_pstrb"}, 32'(bus.pstrb), 32'(r.exp_pstrb));
    chk({ph, "_pprot"}, 32'(bus.pprot), 32'(r.prot));
    chk({ph, "_rsp_valid"}, 32'(bus.rsp_valid), 0);
    chk({ph, "_req_ready"}, 32'(bus.req_ready), 0);
  endtask
  task automatic xfer(input vec_t r);
    int nacc = timed_out(r.waits) ? TO : r.waits + 1;
    chk("idle_req_ready", 32'(bus.req_ready), 1);
    bus.req_valid = 1'b1;
    bus.req_write = r.w;
    bus.req_addr  = r.addr;
    bus.req_wdata = r.wdata;
    bus.req_strb  = r.strb;
    bus.req_prot  = r.prot;
    step();
    bus.req_valid = 1'b0;
    bus.req_write = ~r.w;
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
    bus.req_strb  = 4'($urandom);
    bus.req_prot  = 3'($urandom);
    bus.pready    = 1'($urandom);
    bus.pslverr   = 1'($urandom);
    bus.prdata    = $urandom;
    bus.rsp_ready = 1'b1;
    chk("setup_psel", 32'(bus.psel), 1);
    chk("setup_penable", 32'(bus.penable), 0);
    apb_chk("setup", r);
    step();
    for (int k = 0; k < nacc; k++) begin
      chk("access_psel", 32'(bus.psel), 1);
      chk("access_penable", 32'(bus.penable), 1);
      apb_chk("access", r);
      bus.pready  = (k == r.waits);
      bus.prdata  = (k == r.waits) ? r.prdata : $urandom;
      bus.pslverr = (k == r.waits) ? r.err : 1'($urandom);
      step();
    end
    bus.pready  = 1'b0;
    bus.pslverr = 1'b0;
    for (int k = 0; k <= r.bp; k++) begin
      bus.req_valid = 1'b1;
      bus.rsp_ready = (k == r.bp);
      chk("rsp_valid", 32'(bus.rsp_valid), 1);
      chk("rsp_write", 32'(bus.rsp_write), 32'(r.w));
      chk("rsp_rdata", bus.rsp_rdata, r.exp_rdata);
      chk("rsp_resp", 32'(bus.rsp_resp), 32'(r.exp_resp));
      chk("rsp_psel", 32'(bus.psel), 0);
      chk("rsp_penable", 32'(bus.penable), 0);
      chk("rsp_req_ready", 32'(bus.req_ready), 0);
      step();
    end
    bus.rsp_ready = 1'b0;
    chk("done_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("done_req_ready", 32'(bus.req_ready), 1);
    chk("done_psel", 32'(bus.psel), 0);
    bus.req_valid = 1'b0;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded its time limit");
    $fatal(1);
  end
  initial begin
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_strb  = '0;
    bus.req_prot  = '0;
    bus.rsp_ready = 1'b0;
    bus.prdata    = '0;
    bus.pready    = 1'b0;
    bus.pslverr   = 1'b0;
    tbl[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'd0, 0, 32'h0, 1'b0, 0, 32'h0, 2'b00, 4'hF};
    tbl[1] = '{1'b0, 32'h20, 32'h0BAD0BAD, 4'hF, 3'd2, 3, 32'h12345678, 1'b0, 1, 32'h12345678, 2'b00, 4'h0};
    tbl[2] = '{1'b1, 32'h40, 32'h00C0FFEE, 4'h3, 3'd1, 0, 32'hFFFFFFFF, 1'b1, 0, 32'h0, 2'b10, 4'h3};
    tbl[3] = '{1'b0, 32'h44, 32'h0, 4'h0, 3'd7, 1, 32'hA5A50F0F, 1'b0, 5, 32'hA5A50F0F, 2'b00, 4'h0};
    tbl[4] = '{1'b0, 32'h80, 32'h0, 4'hF, 3'd0, 0, 32'h00000055, 1'b1, 2, 32'h00000055, 2'b10, 4'h0};
    tbl[5] = '{1'b1, 32'hFFFFFFFC, 32'h89ABCDEF, 4'h5, 3'd5, 3, 32'h11111111, 1'b0, 2, 32'h0, 2'b00, 4'h5};
`ifdef APB_TIMEOUT_EN
    tbl[6] = '{1'b0, 32'h100, 32'h0, 4'h0, 3'd0, 7, 32'h0000CAFE, 1'b0, 1, 32'h0, 2'b10, 4'h0};
`else
    tbl[6] = '{1'b0, 32'h100, 32'h0, 4'h0, 3'd0, 7, 32'h0000CAFE, 1'b0, 1, 32'h0000CAFE, 2'b00, 4'h0};
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 1);
    chk("rst_psel", 32'(bus.psel), 0);
    chk("rst_penable", 32'(bus.penable), 0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_rsp_write", 32'(bus.rsp_write), 0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 0);
    chk("rst_rsp_resp", 32'(bus.rsp_resp), 0);
    chk("rst_paddr", bus.paddr, 0);
    chk("rst_pwrite", 32'(bus.pwrite), 0);
    chk("rst_pwdata", bus.pwdata, 0);
    chk("rst_pstrb", 32'(bus.pstrb), 0);
    chk("rst_pprot", 32'(bus.pprot), 0);
    rst = 1'b1;
    step();
    for (int i = 0; i < 7; i++) xfer(tbl[i]);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 32'h30;
    step();
    bus.req_valid = 1'b0;
    bus.pready    = 1'b0;
    repeat (3) step();
    chk("abort_pre_psel", 32'(bus.psel), 1);
    chk("abort_pre_penable", 32'(bus.penable), 1);
    #3 rst = 1'b0;
    #1;
    chk("abort_psel", 32'(bus.psel), 0);
    chk("abort_penable", 32'(bus.penable), 0);
    chk("abort_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("abort_req_ready", 32'(bus.req_ready), 1);
    step();
    rst = 1'b1;
    bus.pready    = 1'b1;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("post_abort_rsp_valid", 32'(bus.rsp_valid), 0);
      chk("post_abort_psel", 32'(bus.psel), 0);
    end
    bus.pready    = 1'b0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 40; i++) begin
      v.w      = 1'($urandom);
      v.addr   = $urandom;
      v.wdata  = $urandom;
      v.strb   = 4'($urandom);
      v.prot   = 3'($urandom);
      v.waits  = int'($urandom_range(0, 6));
      v.prdata = $urandom;
      v.err    = ($urandom_range(0, 3) == 0);
      v.bp     = int'($urandom_range(0, 3));
      xfer(ref_model(v));
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/apb_master_fsm.md
Name: apb_master_fsm

Overview:
- Downstream stage of the AXI4-Lite slave front-end in the AXI4-Lite-to-APB bridge.
- Accepts one captured request (read or write) at a time over a valid/ready command channel.
- Executes it as an APB3/APB4 transfer: SETUP phase, then ACCESS phase.
- Returns read data and a 2-bit AXI response to the front-end over a valid/ready response channel.

Parameters:
- addrWidth, 32, address width of the request and of paddr.
- dataWidth, 32, data width; must be 8, 16 or 32; strobe width is dataWidth/8.
- TIMEOUT_CYCLES, 16, maximum ACCESS-phase wait cycles; used only with APB_TIMEOUT_EN; must be >= 1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  front-end request valid.
- req_ready  out  1  block can accept a request.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  addrWidth  transfer address.
- req_wdata  in  dataWidth  write data.
- req_strb  in  dataWidth/8  write byte strobes.
- req_prot  in  3  protection bits.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  front-end accepts the response.
- rsp_write  out  1  echoes req_write of the completed transfer.
- rsp_rdata  out  dataWidth  read data; 0 for writes.
- rsp_resp  out  2  2'b00 OKAY, 2'b10 SLVERR.
- paddr  out  addrWidth  APB address.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- pwdata  out  dataWidth  APB write data.
- pstrb  out  dataWidth/8  APB strobes; forced to 0 for reads.
- pprot  out  3  APB protection.
- prdata  in  dataWidth  APB read data.
- pready  in  1  APB ready.
- pslverr  in  1  APB slave error.

Behaviour:
- Reset (rst == 0, asynchronous): state IDLE; all outputs 0 except req_ready = 1.
- Reset asserted mid-transfer aborts the transfer immediately: psel/penable drop without completion and no response is produced.
- FSM states, registered Moore outputs:
  - IDLE: req_ready = 1. If req_valid, capture all req_* into registers and go to SETUP. req_ready is 0 in every other state.
  - SETUP: psel = 1, penable = 0, paddr/pwrite/pwdata/pstrb/pprot driven from the registered request. Always go to ACCESS after exactly one cycle.
  - ACCESS: psel = 1, penable = 1, APB outputs held stable. If pready is 0, stay. If pready is 1: capture prdata (reads) and pslverr, then go to RESP.
  - RESP: psel = penable = 0, rsp_valid = 1; rsp_* held stable until rsp_ready. On rsp_ready, go to IDLE.
- Minimum latency: req_valid accepted at edge N; SETUP at N+1, ACCESS at N+2; with pready = 1 at N+2, rsp_valid is high from N+3.
- No back-to-back APB transfers: IDLE is always entered between transfers, so throughput is at most one transfer per 4 cycles.
- pslverr is sampled only when psel & penable & pready; it is ignored otherwise.
- rsp_resp = pslverr ? 2'b10 : 2'b00.
- rsp_rdata = prdata captured for reads; 0 for writes, including on error.
- Request inputs may change freely once accepted; the captured copy is the one used.
- rsp_valid must not drop before rsp_ready. rsp_ready arriving while rsp_valid = 0 has no effect.

Optional Feature:
- APB_TIMEOUT_EN defined:
  - A wait counter clears on entry to ACCESS and increments on each ACCESS cycle with pready = 0.
  - When the counter reaches TIMEOUT_CYCLES, the FSM leaves ACCESS on that edge: psel/penable drop, rsp_resp = 2'b10, rsp_rdata = 0, go to RESP.
  - A pready arriving on the same cycle as the timeout wins: normal completion.
- APB_TIMEOUT_EN undefined: no counter and no timeout; ACCESS waits indefinitely.

Decomposition:
- Shared package axi_apb_pkg holds:
  - resp_t enum (OKAY = 2'b00, EXOKAY = 2'b01, SLVERR = 2'b10, DECERR = 2'b11).
  - apb_state_t enum (IDLE, SETUP, ACCESS, RESP).
  - Default width constants, shared with the AXI4-Lite front-end.
- One natural sub-module: apb_wait_timer, the timeout counter. Instantiate it only under APB_TIMEOUT_EN.

Test Plan:
1. Write: req addr 0x0000_0010, wdata 0xDEAD_BEEF, strb 4'hF, pready = 1 immediately -> SETUP then one ACCESS cycle with paddr 0x10, pwdata 0xDEADBEEF, pwrite = 1; rsp_valid 3 cycles after accept; rsp_resp = 00; rsp_rdata = 0.
2. Read with wait states: addr 0x0000_0020, pready low for 3 ACCESS cycles, prdata 0x1234_5678 on the pready cycle -> APB outputs stable for 4 ACCESS cycles; rsp_rdata = 0x12345678; pstrb = 0.
3. Slave error: write to 0x0000_0040, pslverr = 1 with pready -> rsp_resp = 2'b10.
4. Response backpressure: rsp_ready held low 5 cycles -> rsp_* stable, req_ready = 0 throughout, psel = 0. A second req_valid is not accepted until the cycle after the rsp handshake.
5. Reset mid-ACCESS (pready = 0): drive rst low -> psel/penable/rsp_valid = 0 asynchronously, req_ready = 1; no response appears after release.
6. APB_TIMEOUT_EN with TIMEOUT_CYCLES = 4, pready held low -> leaves ACCESS after 4 wait cycles; rsp_resp = 2'b10, rsp_rdata = 0.
